io_dmem_read_engine: RTL and testbench



---
 rtl/io_dmem_pkg.sv | 28 ++
 rtl/io_rd_fifo.sv | 50 +++++
 rtl/io_dmem_read_engine.sv | 158 +++++++++++++++
 tb/tb_io_dmem_read_engine.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_dmem_pkg.sv
// rtl/io_dmem_pkg.sv - shared types and defaults for the DMem read engine
// IO_RD_LAST_EN adds the last flag to the response beat.
package io_dmem_pkg;

  localparam int AWIDTH_DEF = 14;
  localparam int DWIDTH_DEF = 32;

`ifdef IO_RD_LAST_EN
  localparam int LAST_W = 1;
`else
  localparam int LAST_W = 0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2
  } rd_state_e;

  // Response beat at the default data width.
  typedef struct packed {
    logic [DWIDTH_DEF-1:0] data;
`ifdef IO_RD_LAST_EN
    logic                  last;
`endif
  } rd_beat_t;

endpackage

// File: rtl/io_rd_fifo.sv
// rtl/io_rd_fifo.sv - synchronous response FIFO with push/pop/count interface
// Push on a full FIFO is accepted only when a pop frees a slot in the same cycle.
module io_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && ((count != (PW+1)'(DEPTH)) || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/io_dmem_read_engine.sv
// rtl/io_dmem_read_engine.sv - burst read engine: request -> IO latency -> DMem port A -> response stream
// IO_RD_LAST_EN adds resp_read_data_last on the final beat of each burst.
module io_dmem_read_engine
  import io_dmem_pkg::*;
#(
  parameter int AWIDTH     = AWIDTH_DEF,
  parameter int DWIDTH     = DWIDTH_DEF,
  parameter int IO_LATENCY = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] req_read_addr,
  input  logic              req_read_addr_valid,
  output logic              req_read_addr_ready,
  input  logic [31:0]       req_read_len,
  output logic [DWIDTH-1:0] resp_read_data,
  output logic              resp_read_data_valid,
  input  logic              resp_read_data_ready,
`ifdef IO_RD_LAST_EN
  output logic              resp_read_data_last,
`endif
  output logic [AWIDTH-1:0] dmem_addra,
  output logic [DWIDTH-1:0] dmem_dina,
  output logic [3:0]        dmem_wea,
  input  logic [DWIDTH-1:0] dmem_douta
);

  localparam int LAT_W  = (IO_LATENCY > 0) ? $clog2(IO_LATENCY + 1) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BEAT_W = DWIDTH + LAST_W;

  rd_state_e         state;
  rd_state_e         state_nxt;
  logic [AWIDTH-1:0] cur_addr;
  logic [31:0]       len_q;
  logic [31:0]       issued;
  logic [31:0]       popped;
  logic [LAT_W-1:0]  lat_cnt;

  // rd_v1: address on the RAM port; rd_v2: RAM data valid on dmem_douta.
  logic              rd_v1;
  logic              rd_v2;
  logic [1:0]        inflight;

  logic              accept;
  logic              issue;
  logic              pop;
  logic              burst_done;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [BEAT_W-1:0] push_beat;
  logic [BEAT_W-1:0] head_beat;

  assign dmem_dina = '0;
  assign dmem_wea  = '0;

  assign accept     = req_read_addr_valid && req_read_addr_ready;
  assign inflight   = {1'b0, rd_v1} + {1'b0, rd_v2};
  assign issue      = (state == STREAM) && (issued < len_q) &&
                      ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);
  assign pop        = resp_read_data_valid && resp_read_data_ready;
  assign burst_done = pop && ((popped + 32'd1) == len_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt           = state;
    req_read_addr_ready = 1'b0;
    case (state)
      IDLE: begin
        req_read_addr_ready = !rst;
        // A zero-length request is consumed without leaving IDLE.
        if (accept && (req_read_len != 32'd0))
          state_nxt = (IO_LATENCY > 0) ? WAIT : STREAM;
      end
      WAIT: begin
        if (lat_cnt == LAT_W'(1)) state_nxt = STREAM;
      end
      STREAM: begin
        if (burst_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr   <= '0;
      len_q      <= '0;
      issued     <= '0;
      popped     <= '0;
      lat_cnt    <= '0;
      rd_v1      <= 1'b0;
      rd_v2      <= 1'b0;
      dmem_addra <= '0;
    end else begin
      rd_v1 <= issue;
      rd_v2 <= rd_v1;
      if (accept) begin
        cur_addr <= req_read_addr;
        len_q    <= req_read_len;
        issued   <= '0;
        popped   <= '0;
        lat_cnt  <= LAT_W'(IO_LATENCY);
      end
      if (state == WAIT) lat_cnt <= lat_cnt - 1'b1;
      if (issue) begin
        dmem_addra <= cur_addr;
        cur_addr   <= cur_addr + 1'b1;
        issued     <= issued + 32'd1;
      end
      if (pop) popped <= popped + 32'd1;
    end
  end

`ifdef IO_RD_LAST_EN
  // The last flag travels with the read so it lands in the FIFO beside its data.
  logic rd_l1;
  logic rd_l2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_l1 <= 1'b0;
      rd_l2 <= 1'b0;
    end else begin
      rd_l1 <= issue && (issued == (len_q - 32'd1));
      rd_l2 <= rd_l1;
    end
  end

  assign push_beat           = {dmem_douta, rd_l2};
  assign resp_read_data_last = resp_read_data_valid && head_beat[0];
`else
  assign push_beat = dmem_douta;
`endif

  io_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BEAT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_v2),
    .push_data (push_beat),
    .pop       (pop),
    .pop_data  (head_beat),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign resp_read_data_valid = !fifo_empty;
  assign resp_read_data       = head_beat[BEAT_W-1 -: DWIDTH];

endmodule

// File: tb/tb_io_dmem_read_engine.sv
// tb/tb_io_dmem_read_engine.sv - scoreboard bench for io_dmem_read_engine, two latency builds (10 and 0)
// Checks the last flag when IO_RD_LAST_EN is defined.
module tb_io_dmem_read_engine;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int NI = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  logic [AW-1:0] req_addr  [NI];
  logic          req_valid [NI];
  logic          req_ready [NI];
  logic [31:0]   req_len   [NI];
  logic [DW-1:0] rdata     [NI];
  logic          rvalid    [NI];
  logic          rready    [NI];
  logic [AW-1:0] addra     [NI];
  logic [DW-1:0] dina      [NI];
  logic [3:0]    wea       [NI];
  logic [DW-1:0] douta     [NI];
  logic          rlast     [NI];

  // scoreboard: expected beats {data, last} per instance
  logic [DW:0]   exp_beat [NI][256];
  logic [DW-1:0] got      [NI][256];
  int            exp_wr   [NI];
  int            exp_rd   [NI];
  int            base     [NI];
  int            acc_cyc  [NI];
  bit            waiting  [NI];
  bit            hold     [NI];
  bit            idle_due [NI];
  bit            post_rst [NI];
  bit            prev_stall [NI];
  logic [DW-1:0] prev_data  [NI];
  int            rmode      [NI];
  int            stall_left [NI];

  int n_pass = 0;
  int n_tot  = 0;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return 32'hA500_0000 ^ (32'(a) * 32'h0001_0003);
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 10 : 0;
  endfunction

  task automatic check(input bit ok, input string name, input int inst,
                       input longint act, input longint expv);
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h (cycle %0d)", name, inst, act, expv, cyc);
  endtask

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    io_dmem_read_engine #(
      .AWIDTH     (AW),
      .DWIDTH     (DW),
      .IO_LATENCY ((g == 0) ? 10 : 0),
      .FIFO_DEPTH (4)
    ) u_dut (
      .clk                  (clk),
      .rst                  (rst),
      .req_read_addr        (req_addr[g]),
      .req_read_addr_valid  (req_valid[g]),
      .req_read_addr_ready  (req_ready[g]),
      .req_read_len         (req_len[g]),
      .resp_read_data       (rdata[g]),
      .resp_read_data_valid (rvalid[g]),
      .resp_read_data_ready (rready[g]),
`ifdef IO_RD_LAST_EN
      .resp_read_data_last  (rlast[g]),
`endif
      .dmem_addra           (addra[g]),
      .dmem_dina            (dina[g]),
      .dmem_wea             (wea[g]),
      .dmem_douta           (douta[g])
    );
`ifndef IO_RD_LAST_EN
    assign rlast[g] = 1'b0;
`endif

    always @(posedge clk) douta[g] <= mem_f(addra[g]);

    // consumer: 0 = always ready, 1 = random, 2 = alternating with 3-cycle stalls
    always @(posedge clk) begin
      #1;
      case (rmode[g])
        0: rready[g] = 1'b1;
        1: rready[g] = 1'($urandom_range(0, 1));
        default: begin
          if (stall_left[g] > 0) begin
            rready[g] = 1'b0;
            stall_left[g]--;
          end else if ($urandom_range(0, 9) == 0) begin
            rready[g] = 1'b0;
            stall_left[g] = 2;
          end else begin
            rready[g] = !rready[g];
          end
        end
      endcase
    end

    always @(negedge clk) begin
      logic [DW:0] e;
      if (rst) begin
        check(req_ready[g] == 1'b0, "ready_in_rst", g, req_ready[g], 0);
        exp_rd[g] = exp_wr[g];
        waiting[g] = 0;
        idle_due[g] = 0;
        prev_stall[g] = 0;
        post_rst[g] = 1;
      end else begin
        if (post_rst[g]) begin
          check(rvalid[g] == 1'b0, "valid_after_rst", g, rvalid[g], 0);
          check(addra[g] == '0, "addra_after_rst", g, addra[g], 0);
          check(req_ready[g] == 1'b1, "ready_after_rst", g, req_ready[g], 1);
          post_rst[g] = 0;
        end
        if (idle_due[g]) begin
          check(req_ready[g] == 1'b1, "ready_after_last", g, req_ready[g], 1);
          idle_due[g] = 0;
        end
        if (rvalid[g]) begin
          check(exp_rd[g] != exp_wr[g], "unexpected_beat", g, rdata[g], 0);
          if (exp_rd[g] != exp_wr[g]) begin
            e = exp_beat[g][exp_rd[g] % 256];
            if (waiting[g]) begin
              check(cyc - acc_cyc[g] - 1 == lat_of(g) + 3, "first_latency", g,
                    cyc - acc_cyc[g] - 1, lat_of(g) + 3);
              waiting[g] = 0;
            end
            check(rdata[g] == e[DW:1], "data", g, rdata[g], e[DW:1]);
`ifdef IO_RD_LAST_EN
            check(rlast[g] == e[0], "last", g, rlast[g], e[0]);
`endif
            if (prev_stall[g]) check(rdata[g] == prev_data[g], "stable", g, rdata[g], prev_data[g]);
            if (rready[g]) begin
              got[g][(exp_rd[g] - base[g]) % 256] = rdata[g];
              exp_rd[g]++;
              if (exp_rd[g] == exp_wr[g]) idle_due[g] = 1;
            end
          end
        end else begin
          if (hold[g]) check(waiting[g] || exp_rd[g] == exp_wr[g], "throughput_gap", g,
                             exp_wr[g] - exp_rd[g], 0);
`ifdef IO_RD_LAST_EN
          check(rlast[g] == 1'b0, "last_idle", g, rlast[g], 0);
`endif
        end
        prev_stall[g] = rvalid[g] && !rready[g];
        prev_data[g]  = rdata[g];
        if (req_valid[g] && req_ready[g]) begin
          base[g]    = exp_wr[g];
          acc_cyc[g] = cyc;
          waiting[g] = (req_len[g] != 0);
          for (int k = 0; k < int'(req_len[g]); k++) begin
            exp_beat[g][exp_wr[g] % 256] = {mem_f(AW'(int'(req_addr[g]) + k)), k == int'(req_len[g]) - 1};
            exp_wr[g]++;
          end
        end
      end
    end
  end

  task automatic send(input int i, input int a, input int n);
    int t;
    @(posedge clk);
    #1;
    req_addr[i]  = AW'(a);
    req_len[i]   = n;
    req_valid[i] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready[i] && t < 300);
    check(req_ready[i] == 1'b1, "req_accept_timeout", i, t, 300);
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int t;
    t = 0;
    while (t < 3000 && !(exp_rd[i] == exp_wr[i] && !waiting[i] && req_ready[i])) begin
      @(negedge clk);
      t++;
    end
    check(t < 3000, "burst_timeout", i, t, 3000);
  endtask

  initial begin
    int t;
    int ii;
    for (int i = 0; i < NI; i++) begin
      req_valid[i] = 1'b0; req_addr[i] = '0; req_len[i] = '0;
      exp_wr[i] = 0; exp_rd[i] = 0; base[i] = 0; acc_cyc[i] = 0;
      waiting[i] = 0; hold[i] = 0; idle_due[i] = 0; post_rst[i] = 0;
      prev_stall[i] = 0; rmode[i] = 0; stall_left[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 9-beat burst, ready held high, latency 10
    hold[0] = 1;
    send(0, 0, 9);
    wait_idle(0);
    hold[0] = 0;
    check(got[0][0] == 32'hA500_0000, "t1_beat0", 0, got[0][0], 32'hA500_0000);
    check(got[0][8] == 32'hA508_0018, "t1_beat8", 0, got[0][8], 32'hA508_0018);

    // 64 beats under alternating ready and stalls
    rmode[0] = 2;
    send(0, 9, 64);
    wait_idle(0);
    rmode[0] = 0;

    // zero-length request, then a single beat
    send(0, 5, 0);
    repeat (15) begin
      @(negedge clk);
      check(req_ready[0] == 1'b1, "len0_ready", 0, req_ready[0], 1);
    end
    send(0, 5, 1);
    wait_idle(0);
    check(got[0][0] == 32'hA505_000F, "len1_beat", 0, got[0][0], 32'hA505_000F);

    // address wrap
    rmode[0] = 1;
    send(0, 16382, 4);
    wait_idle(0);
    rmode[0] = 0;
    check(got[0][0] == 32'h9AFE_BFFA, "wrap_beat0", 0, got[0][0], 32'h9AFE_BFFA);
    check(got[0][1] == 32'h9AFF_BFFD, "wrap_beat1", 0, got[0][1], 32'h9AFF_BFFD);
    check(got[0][2] == 32'hA500_0000, "wrap_beat2", 0, got[0][2], 32'hA500_0000);
    check(got[0][3] == 32'hA501_0003, "wrap_beat3", 0, got[0][3], 32'hA501_0003);

    // reset mid-burst
    send(0, 200, 20);
    t = 0;
    while (exp_rd[0] - base[0] < 3 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(t < 200, "beat3_timeout", 0, t, 200);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(negedge clk);
    send(0, 100, 2);
    wait_idle(0);
    check(got[0][0] == 32'hA564_012C, "post_rst_beat0", 0, got[0][0], 32'hA564_012C);
    check(got[0][1] == 32'hA565_012F, "post_rst_beat1", 0, got[0][1], 32'hA565_012F);

    // zero latency, 16 beats at full rate, then back-to-back requests
    hold[1] = 1;
    send(1, 50, 16);
    wait_idle(1);
    check(got[1][15] == mem_f(14'd65), "lat0_beat15", 1, got[1][15], mem_f(14'd65));
    send(1, 7, 3);
    send(1, 3000, 5);
    wait_idle(1);
    hold[1] = 0;

    // random bursts on both instances
    for (int r = 0; r < 16; r++) begin
      ii = r % NI;
      rmode[ii] = $urandom_range(0, 2);
      send(ii, $urandom_range(0, 16383), $urandom_range(1, 40));
      wait_idle(ii);
      rmode[ii] = 0;
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
